ram_port_arbiter: RTL and testbench

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

---
 rtl/ram_port_arbiter_if.sv | 28 ++
 rtl/ram_port_arbiter.sv | 58 +++++
 tb/tb_ram_port_arbiter.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: requester handshakes and the single RAM port
// shared by ram_port_arbiter and its environment.
interface ram_port_arbiter_if #(
    parameter int WIDTH    = 8,
    parameter int DEPTHBIT = 4
);
    logic                req0, req1;
    logic                we0, we1;
    logic [DEPTHBIT-1:0] addr0, addr1;
    logic [WIDTH-1:0]    wdata0, wdata1;
    logic                gnt0, gnt1;
    logic [WIDTH-1:0]    rdata0, rdata1;
    logic                rvalid0, rvalid1;
    logic [DEPTHBIT-1:0] ram_addr;
    logic [WIDTH-1:0]    ram_wdata;
    logic                ram_we;
    logic [WIDTH-1:0]    ram_rdata;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_rdata,
        output gnt0, gnt1, rdata0, rdata1, rvalid0, rvalid1, ram_addr, ram_wdata, ram_we
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_rdata,
        input  gnt0, gnt1, rdata0, rdata1, rvalid0, rvalid1, ram_addr, ram_wdata, ram_we
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin sharing of one RAM port between two requesters,
// with registered grant/command and per-requester registered read data.
module ram_port_arbiter #(
    parameter int WIDTH    = 8,
    parameter int DEPTHBIT = 4
) (
    input logic              clk,
    input logic              rst_n,
    ram_port_arbiter_if.slave bus
);
    logic                ptr;
    logic                elig0, elig1, pick0, pick1, pick, sel_we;
    logic [DEPTHBIT-1:0] sel_addr;
    logic [WIDTH-1:0]    sel_wdata;
    logic                rd_done0, rd_done1;

    // A requester whose grant is showing this cycle still holds req; mask it.
    always_comb begin
        elig0     = bus.req0 & ~bus.gnt0;
        elig1     = bus.req1 & ~bus.gnt1;
        pick0     = elig0 & (~elig1 | ~ptr);
        pick1     = elig1 & ~pick0;
        pick      = pick0 | pick1;
        sel_we    = pick1 ? bus.we1 : bus.we0;
        sel_addr  = pick1 ? bus.addr1 : bus.addr0;
        sel_wdata = pick1 ? bus.wdata1 : bus.wdata0;
        rd_done0  = bus.gnt0 & ~bus.ram_we;
        rd_done1  = bus.gnt1 & ~bus.ram_we;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr           <= 1'b0;
            bus.gnt0      <= 1'b0;
            bus.gnt1      <= 1'b0;
            bus.ram_we    <= 1'b0;
            bus.ram_addr  <= '0;
            bus.ram_wdata <= '0;
            bus.rvalid0   <= 1'b0;
            bus.rvalid1   <= 1'b0;
            bus.rdata0    <= '0;
            bus.rdata1    <= '0;
        end else begin
            bus.gnt0    <= pick0;
            bus.gnt1    <= pick1;
            bus.ram_we  <= pick & sel_we;
            bus.rvalid0 <= rd_done0;
            bus.rvalid1 <= rd_done1;
            if (pick) begin
                ptr           <= pick0;
                bus.ram_addr  <= sel_addr;
                bus.ram_wdata <= sel_wdata;
            end
            if (rd_done0) bus.rdata0 <= bus.ram_rdata;
            if (rd_done1) bus.rdata1 <= bus.ram_rdata;
        end
    end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed stimulus with a grant/read-data scoreboard
// checked by a negedge monitor against a behavioural RAM.
module tb_ram_port_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic preload = 1'b1;
    logic [7:0] mem [16];
    int passed = 0;
    int total = 0;

    typedef struct { bit port; bit we; logic [3:0] addr; logic [7:0] wdata; } gnt_t;
    typedef struct { bit port; logic [7:0] data; } rd_t;
    gnt_t gq[$];
    rd_t  rq[$];
    bit prev_rd0 = 0, prev_rd1 = 0, prev_rst = 0;

    ram_port_arbiter_if #(.WIDTH(8), .DEPTHBIT(4)) bus ();
    ram_port_arbiter #(.WIDTH(8), .DEPTHBIT(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'h10 + 8'(i);
        end else if (bus.ram_we) begin
            mem[bus.ram_addr] <= bus.ram_wdata;
        end
    end
    assign bus.ram_rdata = mem[bus.ram_addr];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check_idle(input string name);
        chk(name, {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.ram_we,
                   bus.ram_addr, bus.ram_wdata, bus.rdata0, bus.rdata1}, 0);
    endtask

    always @(negedge clk) begin : mon
        gnt_t g;
        rd_t r;
        if (bus.gnt0 | bus.gnt1) begin
            chk("gnt_excl", {63'd0, bus.gnt0 & bus.gnt1}, 0);
            if (gq.size() == 0) chk("unexpected_gnt", {62'd0, bus.gnt1, bus.gnt0}, 0);
            else begin
                g = gq.pop_front();
                chk("gnt_port", {63'd0, bus.gnt1}, {63'd0, g.port});
                chk("gnt_we", {63'd0, bus.ram_we}, {63'd0, g.we});
                chk("gnt_addr", {60'd0, bus.ram_addr}, {60'd0, g.addr});
                if (g.we) chk("gnt_wdata", {56'd0, bus.ram_wdata}, {56'd0, g.wdata});
            end
        end else chk("idle_we", {63'd0, bus.ram_we}, 0);
        chk("rvalid0_timing", {63'd0, bus.rvalid0}, {63'd0, prev_rd0 & prev_rst});
        chk("rvalid1_timing", {63'd0, bus.rvalid1}, {63'd0, prev_rd1 & prev_rst});
        if (bus.rvalid0 | bus.rvalid1) begin
            chk("rvalid_excl", {63'd0, bus.rvalid0 & bus.rvalid1}, 0);
            if (rq.size() == 0) chk("unexpected_rvalid", {62'd0, bus.rvalid1, bus.rvalid0}, 0);
            else begin
                r = rq.pop_front();
                chk("rd_port", {63'd0, bus.rvalid1}, {63'd0, r.port});
                chk("rdata", {56'd0, r.port ? bus.rdata1 : bus.rdata0}, {56'd0, r.data});
            end
        end
        prev_rd0 = bus.gnt0 & ~bus.ram_we;
        prev_rd1 = bus.gnt1 & ~bus.ram_we;
        prev_rst = rst_n;
    end

    task automatic issue(input bit p, input bit we, input logic [3:0] a, input logic [7:0] d);
        int n = 0;
        if (p) begin bus.req1 = 1; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d; end
        else   begin bus.req0 = 1; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d; end
        do begin
            @(negedge clk);
            n++;
        end while (!(p ? bus.gnt1 : bus.gnt0) && n < 30);
        if (n >= 30) chk("gnt_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic drop(input bit p);
        if (p) bus.req1 = 0;
        else bus.req0 = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
        bus.addr0 = 0; bus.addr1 = 0; bus.wdata0 = 0; bus.wdata1 = 0;
        // reset with both requesting: nothing moves until release, then 0 before 1
        gq.push_back('{0, 0, 4'd1, 8'h00});
        gq.push_back('{1, 0, 4'd2, 8'h00});
        rq.push_back('{0, 8'h11});
        rq.push_back('{1, 8'h12});
        fork
            begin issue(0, 0, 4'd1, 8'h00); drop(0); end
            begin issue(1, 0, 4'd2, 8'h00); drop(1); end
            begin
                @(posedge clk); #1 preload = 0;
                @(negedge clk); check_idle("reset_a");
                @(negedge clk); check_idle("reset_b");
                @(posedge clk); #1 rst_n = 1;
            end
        join
        // contention: strict alternation starting with requester 0
        for (int i = 0; i < 3; i++) begin
            gq.push_back('{0, 0, 4'd1, 8'h00});
            gq.push_back('{1, 0, 4'd2, 8'h00});
            rq.push_back('{0, 8'h11});
            rq.push_back('{1, 8'h12});
        end
        fork
            begin for (int i = 0; i < 3; i++) issue(0, 0, 4'd1, 8'h00); drop(0); end
            begin for (int j = 0; j < 3; j++) issue(1, 0, 4'd2, 8'h00); drop(1); end
        join
        idle(3);
        // last grant was 1: requester 0 wins after idle
        gq.push_back('{0, 0, 4'd4, 8'h00});
        gq.push_back('{1, 0, 4'd4, 8'h00});
        rq.push_back('{0, 8'h14});
        rq.push_back('{1, 8'h14});
        fork
            begin issue(0, 0, 4'd4, 8'h00); drop(0); end
            begin issue(1, 0, 4'd4, 8'h00); drop(1); end
        join
        idle(2);
        // write then read on requester 0
        gq.push_back('{0, 1, 4'd3, 8'hA5});
        gq.push_back('{0, 0, 4'd3, 8'h00});
        rq.push_back('{0, 8'hA5});
        issue(0, 1, 4'd3, 8'hA5);
        issue(0, 0, 4'd3, 8'h00);
        drop(0);
        idle(3);
        // last grant was 0: requester 1 wins
        gq.push_back('{1, 0, 4'd6, 8'h00});
        gq.push_back('{0, 0, 4'd7, 8'h00});
        rq.push_back('{1, 8'h16});
        rq.push_back('{0, 8'h17});
        fork
            begin issue(0, 0, 4'd7, 8'h00); drop(0); end
            begin issue(1, 0, 4'd6, 8'h00); drop(1); end
        join
        idle(2);
        gq.push_back('{1, 1, 4'd9, 8'h77});
        issue(1, 1, 4'd9, 8'h77);
        drop(1);
        idle(2);
        chk("write_mem9", {56'd0, mem[9]}, 64'h77);
        // withdrawal: requester 1 loses the tie and drops before it is served
        gq.push_back('{0, 0, 4'd3, 8'h00});
        rq.push_back('{0, 8'hA5});
        fork
            begin issue(0, 0, 4'd3, 8'h00); drop(0); end
            begin
                bus.req1 = 1; bus.we1 = 1; bus.addr1 = 4'd1; bus.wdata1 = 8'hEE;
                @(posedge clk); #1 bus.req1 = 0;
            end
        join
        idle(3);
        chk("withdraw_mem1", {56'd0, mem[1]}, 64'h11);
        // reset lands on a write grant: write completes, outputs clear
        gq.push_back('{0, 1, 4'd5, 8'h3C});
        bus.req0 = 1; bus.we0 = 1; bus.addr0 = 4'd5; bus.wdata0 = 8'h3C;
        @(posedge clk); #1;
        bus.req0 = 0;
        rst_n = 0;
        @(posedge clk); #1;
        @(negedge clk);
        check_idle("reset_mid");
        chk("reset_mid_mem5", {56'd0, mem[5]}, 64'h3C);
        @(posedge clk); #1 rst_n = 1;
        gq.push_back('{1, 0, 4'd5, 8'h00});
        rq.push_back('{1, 8'h3C});
        issue(1, 0, 4'd5, 8'h00);
        drop(1);
        idle(4);
        chk("gnt_queue_empty", gq.size(), 0);
        chk("rd_queue_empty", rq.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", passed, total);
        $fatal(1);
    end
endmodule
